// File: rtl/branch_redirect_ctrl.sv
// PC sequencer and branch-redirect controller (static predict-not-taken).
// Optional branch statistics counters are enabled with `define BRANCH_STATS_EN.
module branch_redirect_ctrl #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  output logic [PC_W-1:0]   pc,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              redirect,
  output logic              in_redirect
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_taken
`endif
);

  typedef enum logic {S_RUN, S_REDIRECT} state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_flush_ifid;
  logic            r_flush_idex;
  logic            r_redirect;
  logic            w_take;

  // br_taken is masked by br_valid so an undriven comparator cannot leak through
  assign w_take = br_valid & br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_pc         <= RESET_PC;
      r_flush_ifid <= 1'b0;
      r_flush_idex <= 1'b0;
      r_redirect   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_take) begin
            // the branch is older than the stalled instruction, so it wins
            r_pc         <= br_target;
            r_flush_ifid <= 1'b1;
            r_flush_idex <= 1'b1;
            r_redirect   <= 1'b1;
            r_state      <= S_REDIRECT;
          end else begin
            if (!stall) r_pc <= r_pc + PC_W'(1);
            r_flush_ifid <= 1'b0;
            r_flush_idex <= 1'b0;
            r_redirect   <= 1'b0;
            r_state      <= S_RUN;
          end
        end
        default: begin
          // EX holds a flushed bubble here; any branch it shows is ignored
          if (!stall) r_pc <= r_pc + PC_W'(1);
          r_flush_ifid <= 1'b0;
          r_flush_idex <= 1'b0;
          r_redirect   <= 1'b0;
          r_state      <= S_RUN;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign flush_ifid  = r_flush_ifid;
  assign flush_idex  = r_flush_idex;
  assign redirect    = r_redirect;
  assign in_redirect = (r_state == S_REDIRECT);

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] r_stat_branches;
  logic [STAT_W-1:0] r_stat_taken;
  logic              w_run;

  assign w_run = (r_state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_branches <= '0;
      r_stat_taken    <= '0;
    end else begin
      if (w_run && br_valid && (r_stat_branches != '1))
        r_stat_branches <= r_stat_branches + STAT_W'(1);
      if (w_run && w_take && (r_stat_taken != '1))
        r_stat_taken <= r_stat_taken + STAT_W'(1);
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_taken    = r_stat_taken;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl.
// Build with +define+BRANCH_STATS_EN to also check the statistics counters.
module tb_branch_redirect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       br_valid;
  logic       br_taken;
  logic [7:0] br_target;
  logic [7:0] pc;
  logic       flush_ifid;
  logic       flush_idex;
  logic       redirect;
  logic       in_redirect;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_taken;
`endif

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  branch_redirect_ctrl #(
    .PC_W    (8),
    .RESET_PC(8'h00),
    .STAT_W  (16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .pc         (pc),
    .flush_ifid (flush_ifid),
    .flush_idex (flush_idex),
    .redirect   (redirect),
    .in_redirect(in_redirect)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_taken   (stat_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] exp_pc, input logic exp_pulse,
                           input logic exp_inr);
    chk({tag, ".pc"}, {24'd0, pc}, {24'd0, exp_pc});
    chk({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, exp_pulse});
    chk({tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, exp_pulse});
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, exp_pulse});
    chk({tag, ".in_redirect"}, {31'd0, in_redirect}, {31'd0, exp_inr});
  endtask

  task automatic branch(input logic v, input logic t, input logic [7:0] tgt);
    br_valid  = v;
    br_taken  = t;
    br_target = tgt;
  endtask

  initial begin
    int unsigned guard;
    rst = 1'b1; stall = 1'b0;
    branch(1'b0, 1'b0, 8'h00);
    tick(); tick();
    chk_state("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    chk_state("post_reset", 8'h00, 1'b0, 1'b0);
    tick(); chk_state("seq1", 8'h01, 1'b0, 1'b0);
    tick(); chk_state("seq2", 8'h02, 1'b0, 1'b0);
    tick(); chk_state("seq3", 8'h03, 1'b0, 1'b0);

    // run sequentially up to FE, then across the wrap
    guard = 0;
    while (pc !== 8'hFE && guard < 300) begin
      tick();
      guard++;
    end
    chk_state("reach_fe", 8'hFE, 1'b0, 1'b0);
    tick(); chk_state("wrap_ff", 8'hFF, 1'b0, 1'b0);
    tick(); chk_state("wrap_00", 8'h00, 1'b0, 1'b0);
    tick(); chk_state("wrap_01", 8'h01, 1'b0, 1'b0);

    repeat (4) tick();
    chk_state("at_05", 8'h05, 1'b0, 1'b0);
    stall = 1'b1;
    tick(); chk_state("stall1", 8'h05, 1'b0, 1'b0);
    tick(); chk_state("stall2", 8'h05, 1'b0, 1'b0);
    tick(); chk_state("stall3", 8'h05, 1'b0, 1'b0);
    stall = 1'b0;
    tick(); chk_state("unstall", 8'h06, 1'b0, 1'b0);

    repeat (10) tick();
    chk_state("at_10", 8'h10, 1'b0, 1'b0);
    branch(1'b1, 1'b1, 8'h40);
    tick(); chk_state("take40", 8'h40, 1'b1, 1'b1);
    branch(1'b0, 1'b0, 8'h00);
    tick(); chk_state("after40", 8'h41, 1'b0, 1'b0);

    // taken branch beats stall; second branch in REDIRECT is ignored
    stall = 1'b1;
    branch(1'b1, 1'b1, 8'h20);
    tick(); chk_state("take20_stall", 8'h20, 1'b1, 1'b1);
    stall = 1'b0;
    branch(1'b1, 1'b1, 8'h80);
    tick(); chk_state("ignore80", 8'h21, 1'b0, 1'b0);
    branch(1'b0, 1'b0, 8'h00);
    tick(); chk_state("after_ignore", 8'h22, 1'b0, 1'b0);

    branch(1'b1, 1'b0, 8'h99);
    tick(); chk_state("not_taken", 8'h23, 1'b0, 1'b0);
    branch(1'b0, 1'bx, 8'h77);
    tick(); chk_state("x_taken", 8'h24, 1'b0, 1'b0);

    // targets equal to pc and pc+1 still redirect
    branch(1'b1, 1'b1, 8'h24);
    tick(); chk_state("tgt_eq_pc", 8'h24, 1'b1, 1'b1);
    branch(1'b0, 1'b0, 8'h00);
    tick(); chk_state("after_eq", 8'h25, 1'b0, 1'b0);
    branch(1'b1, 1'b1, 8'h26);
    tick(); chk_state("tgt_pc_p1", 8'h26, 1'b1, 1'b1);
    branch(1'b0, 1'b0, 8'h00);
    tick(); chk_state("after_p1", 8'h27, 1'b0, 1'b0);

    // stall during REDIRECT holds pc
    branch(1'b1, 1'b1, 8'h50);
    tick(); chk_state("take50", 8'h50, 1'b1, 1'b1);
    branch(1'b0, 1'b0, 8'h00);
    stall = 1'b1;
    tick(); chk_state("redir_stall", 8'h50, 1'b0, 1'b0);
    stall = 1'b0;
    tick(); chk_state("redir_unstall", 8'h51, 1'b0, 1'b0);

    // reset while in REDIRECT
    branch(1'b1, 1'b1, 8'h90);
    tick(); chk_state("take90", 8'h90, 1'b1, 1'b1);
    rst = 1'b1;
    branch(1'b1, 1'b1, 8'hA0);
    tick(); chk_state("rst_in_redir", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    branch(1'b0, 1'b0, 8'h00);
    tick(); chk_state("rst_resume", 8'h01, 1'b0, 1'b0);

`ifdef BRANCH_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stat_br_rst0", {16'd0, stat_branches}, 32'd0);
    chk("stat_tk_rst0", {16'd0, stat_taken}, 32'd0);
    branch(1'b1, 1'b0, 8'h00); tick();   // branch 1
    branch(1'b1, 1'b1, 8'h30); tick();   // branch 2, taken 1
    branch(1'b1, 1'b1, 8'h60); tick();   // in REDIRECT, not counted
    branch(1'b1, 1'b0, 8'h00); tick();   // branch 3
    stall = 1'b1;
    branch(1'b1, 1'b0, 8'h00); tick();   // branch 4
    stall = 1'b0;
    branch(1'b1, 1'b1, 8'h70); tick();   // branch 5, taken 2
    branch(1'b0, 1'b0, 8'h00); tick();
    chk("stat_branches", {16'd0, stat_branches}, 32'd5);
    chk("stat_taken", {16'd0, stat_taken}, 32'd2);
    chk("stat_pc", {24'd0, pc}, 32'h71);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stat_br_clr", {16'd0, stat_branches}, 32'd0);
    chk("stat_tk_clr", {16'd0, stat_taken}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
